// File: rtl/reg_mem_wb_elastic.sv
// MEM/WB pipeline register with valid/ready handshake, a 2-entry skid buffer,
// flush, bubble masking of write-back control and saturating perf counters.
module reg_mem_wb_elastic #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] RegDst_address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   _WB,
  output logic [DATA_W-1:0] _read_data,
  output logic [DATA_W-1:0] _ALU_result,
  output logic [ADDR_W-1:0] _RegDst_address,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [WB_W-1:0]     main_wb_q, skid_wb_q;
  logic [DATA_W-1:0]   main_rd_q, skid_rd_q;
  logic [DATA_W-1:0]   main_alu_q, skid_alu_q;
  logic [ADDR_W-1:0]   main_addr_q, skid_addr_q;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                main_valid;
  logic                in_fire, out_fire;
  logic                main_ld, skid_ld, main_from_skid;

  assign main_valid = (state_q != EMPTY);
  assign in_fire    = in_valid & ready_q;
  assign out_fire   = main_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_ld = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          skid_ld = 1'b1;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over every transition; payload writes are harmless since
    // the entries are marked invalid.
    if (flush) state_d = EMPTY;
    ready_d = (state_d != TWO);
  end

  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (clr_cnt) begin
      bubble_d = '0;
      stall_d  = '0;
    end else if (!main_valid) begin
      if (bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
    end else if (!out_ready) begin
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b0;
      main_wb_q   <= '0;
      main_rd_q   <= '0;
      main_alu_q  <= '0;
      main_addr_q <= '0;
      skid_wb_q   <= '0;
      skid_rd_q   <= '0;
      skid_alu_q  <= '0;
      skid_addr_q <= '0;
      bubble_q    <= '0;
      stall_q     <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
      if (main_ld) begin
        main_wb_q   <= WB;
        main_rd_q   <= read_data;
        main_alu_q  <= ALU_result;
        main_addr_q <= RegDst_address;
      end else if (main_from_skid) begin
        main_wb_q   <= skid_wb_q;
        main_rd_q   <= skid_rd_q;
        main_alu_q  <= skid_alu_q;
        main_addr_q <= skid_addr_q;
      end
      if (skid_ld) begin
        skid_wb_q   <= WB;
        skid_rd_q   <= read_data;
        skid_alu_q  <= ALU_result;
        skid_addr_q <= RegDst_address;
      end
    end
  end

  assign in_ready        = ready_q;
  assign out_valid       = main_valid;
  assign _WB             = main_valid ? main_wb_q : '0;
  assign _read_data      = main_rd_q;
  assign _ALU_result     = main_alu_q;
  assign _RegDst_address = main_addr_q;
  assign bubble_cnt      = bubble_q;
  assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_reg_mem_wb_elastic.sv
// Randomised and directed bench for reg_mem_wb_elastic against a queue-based model.
module tb_reg_mem_wb_elastic;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned WW = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [WW-1:0] wb;
    logic [DW-1:0] rd;
    logic [DW-1:0] alu;
    logic [AW-1:0] addr;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, clr_cnt, in_valid, in_ready, out_valid, out_ready;
  logic [WW-1:0] WB, _WB;
  logic [DW-1:0] read_data, ALU_result, _read_data, _ALU_result;
  logic [AW-1:0] RegDst_address, _RegDst_address;
  logic [CW-1:0] bubble_cnt, stall_cnt;

  reg_mem_wb_elastic #(.DATA_W(DW), .ADDR_W(AW), .WB_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .WB(WB), .read_data(read_data),
    .ALU_result(ALU_result), .RegDst_address(RegDst_address),
    .out_valid(out_valid), .out_ready(out_ready), ._WB(_WB),
    ._read_data(_read_data), ._ALU_result(_ALU_result),
    ._RegDst_address(_RegDst_address), .bubble_cnt(bubble_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight beats in order, ready flag, plain counters.
  beat_t       q[$];
  logic        m_rdy;
  int unsigned m_bub, m_stall;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.wb   = WW'($urandom);
    b.rd   = {$urandom, $urandom};
    b.alu  = {$urandom, $urandom};
    b.addr = AW'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(input logic [WW-1:0] wb, input logic [DW-1:0] v,
                               input logic [AW-1:0] a);
    beat_t b;
    b.wb = wb; b.rd = v; b.alu = v; b.addr = a;
    return b;
  endfunction

  task automatic check_outputs();
    beat_t h;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (q.size() > 0) begin
      h = q[0];
      chk("_WB", 64'(_WB), 64'(h.wb));
      chk("_read_data", _read_data, h.rd);
      chk("_ALU_result", _ALU_result, h.alu);
      chk("_RegDst_address", 64'(_RegDst_address), 64'(h.addr));
    end else begin
      chk("_WB_bubble", 64'(_WB), 64'd0);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_edge(input logic ifire, input logic ordy, input logic fl,
                            input logic cc, input beat_t b);
    logic ofire;
    ofire = (q.size() > 0) && ordy;
    if (cc) begin
      m_bub = 0; m_stall = 0;
    end else if (q.size() == 0) begin
      m_bub = sat_inc(m_bub);
    end else if (!ordy) begin
      m_stall = sat_inc(m_stall);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(b);
    end
    m_rdy = (q.size() < 2);
  endtask

  // Entered at posedge+1; drives, checks pre-edge outputs, advances one edge.
  task automatic drive_cycle(input logic iv, input logic ordy, input logic fl,
                             input logic cc, input beat_t b, input logic do_chk);
    logic ifire;
    in_valid = iv; out_ready = ordy; flush = fl; clr_cnt = cc;
    WB = b.wb; read_data = b.rd; ALU_result = b.alu; RegDst_address = b.addr;
    #1;
    if (do_chk) check_outputs();
    ifire = iv && m_rdy;
    @(posedge clk);
    model_edge(ifire, ordy, fl, cc, b);
    #1;
  endtask

  task automatic reset_model();
    q.delete();
    m_rdy = 1'b0; m_bub = 0; m_stall = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
  endtask

  beat_t nb;

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    WB = '0; read_data = '0; ALU_result = '0; RegDst_address = '0;
    reset_model();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_WB", 64'(_WB), 64'd0);
    chk("rst_read_data", _read_data, 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    release_reset();

    // Streaming at full rate.
    drive_cycle(1, 1, 0, 0, mk(2'b01, 64'h11, 6'd1), 1);
    drive_cycle(1, 1, 0, 0, mk(2'b10, 64'h22, 6'd2), 1);
    drive_cycle(1, 1, 0, 0, mk(2'b11, 64'h33, 6'd3), 1);
    drive_cycle(0, 1, 0, 0, '0, 1);
    drive_cycle(0, 1, 0, 0, '0, 1);
    chk("stream_stall_zero", 64'(stall_cnt), 64'd0);

    // Back-pressure fills the skid entry, then drains in order.
    drive_cycle(1, 0, 0, 0, mk(2'b01, 64'hA, 6'd10), 1);
    drive_cycle(1, 0, 0, 0, mk(2'b10, 64'hB, 6'd11), 1);
    chk("two_in_ready", 64'(in_ready), 64'd0);
    drive_cycle(0, 1, 0, 0, '0, 1);
    drive_cycle(0, 1, 0, 0, '0, 1);
    drive_cycle(0, 1, 0, 0, '0, 1);

    // Flush in TWO with a competing input beat.
    drive_cycle(1, 0, 0, 0, mk(2'b11, 64'h1, 6'd4), 1);
    drive_cycle(1, 0, 0, 0, mk(2'b11, 64'h2, 6'd5), 1);
    drive_cycle(1, 0, 1, 0, mk(2'b11, 64'h44, 6'd6), 1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_WB", 64'(_WB), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    drive_cycle(0, 1, 0, 0, '0, 1);

    // Flush from ONE while the head is consumed and a new beat arrives.
    drive_cycle(1, 1, 0, 0, mk(2'b01, 64'h55, 6'd7), 1);
    drive_cycle(1, 1, 1, 0, mk(2'b01, 64'h66, 6'd8), 1);
    drive_cycle(0, 1, 0, 0, '0, 1);

    // Wide payload bit-exactness.
    nb.wb = 2'b10; nb.rd = 64'hDEADBEEF_CAFEF00D; nb.alu = 64'h0123_4567_89AB_CDEF; nb.addr = 6'd63;
    drive_cycle(1, 0, 0, 0, nb, 1);
    chk("wide_read_data", _read_data, 64'hDEADBEEF_CAFEF00D);
    chk("wide_addr", 64'(_RegDst_address), 64'd63);
    drive_cycle(0, 1, 0, 0, '0, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 32) == 0,
                  ($urandom % 64) == 0, rand_beat(), 1);
    end
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 0, 0, '0, 1);

    // Bubble counter saturation, then clear.
    drive_cycle(0, 1, 0, 1, '0, 1);
    for (int i = 0; i < 70000; i++) drive_cycle(0, 1, 0, 0, '0, (i % 256) == 0);
    chk("bubble_saturated", 64'(bubble_cnt), 64'hFFFF);
    drive_cycle(0, 1, 0, 0, '0, 1);
    chk("bubble_still_sat", 64'(bubble_cnt), 64'hFFFF);
    drive_cycle(0, 1, 0, 1, '0, 1);
    chk("bubble_cleared", 64'(bubble_cnt), 64'd0);

    // Asynchronous reset while holding a beat with _WB=2'b11.
    drive_cycle(1, 0, 0, 0, mk(2'b11, 64'h77, 6'd9), 1);
    chk("pre_reset_WB", 64'(_WB), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_WB", 64'(_WB), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    chk("async_stall", 64'(stall_cnt), 64'd0);
    reset_model();
    release_reset();
    drive_cycle(1, 1, 0, 0, mk(2'b01, 64'h88, 6'd12), 1);
    drive_cycle(0, 1, 0, 0, '0, 1);
    drive_cycle(0, 1, 0, 0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_mem_wb_elastic.md
Name: reg_mem_wb_elastic

Overview:
- Parametrised MEM/WB pipeline stage register, successor to the fixed-width MEM/WB latch.
- Adds a valid/ready handshake with a 2-entry skid buffer, so write-back back-pressure does not create a combinational ready path into MEM.
- Adds flush (bubble insertion), write-back-control masking on bubbles, and saturating performance counters for bubble and stall cycles.
- Sits between the MEM stage and the register-file write port.

Parameters:
- DATA_W, 32, width of read_data and ALU_result.
- ADDR_W, 5, width of the destination register address.
- WB_W, 2, width of the write-back control bundle.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  drop all held entries at the next edge.
- clr_cnt  in  1  synchronous clear of both counters.
- in_valid  in  1  MEM presents a beat.
- in_ready  out  1  stage can accept a beat.
- WB  in  WB_W  write-back control.
- read_data  in  DATA_W  memory load data.
- ALU_result  in  DATA_W  ALU result.
- RegDst_address  in  ADDR_W  destination register.
- out_valid  out  1  beat presented to WB.
- out_ready  in  1  WB accepts the beat.
- _WB  out  WB_W  registered control, forced to 0 when out_valid=0.
- _read_data  out  DATA_W  registered load data.
- _ALU_result  out  DATA_W  registered ALU result.
- _RegDst_address  out  ADDR_W  registered destination.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: a main entry drives the outputs; a skid entry holds an overflow beat.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst_n low, asynchronous):
  - Both entries are invalid and all payload registers are 0.
  - out_valid=0, _WB=0, both counters 0.
  - in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- in_ready = !skid_valid, driven from a register only, with no combinational path from out_ready.
- States are defined by (main_valid, skid_valid): EMPTY (0,0), ONE (1,0), TWO (1,1). The state (0,1) is illegal.
- EMPTY:
  - in_fire: main <= input, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire: main <= input, stay in ONE.
  - in_fire & !out_fire: skid <= input, go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- TWO (in_ready=0):
  - out_fire: main <= skid, go to ONE.
  - Otherwise hold.
- Latency and throughput:
  - An in_fire in cycle N gives out_valid with that payload in cycle N+1 if the stage was EMPTY, or ONE with out_fire in N.
  - Sustained throughput is 1 beat per cycle with out_ready held at 1.
- Order is strictly FIFO; no beat is duplicated or dropped except by flush.
- Flush:
  - At the edge where flush=1, go to EMPTY, overriding all other transitions.
  - A coincident in_fire is discarded, and a coincident out_fire still counts as consumed downstream.
  - Payload registers may retain stale data, but _WB reads 0 because out_valid=0.
- Bubble masking: _WB = main_valid ? main_WB : 0, so the register file is never written on a bubble.
- Counters:
  - bubble_cnt increments on each edge where out_valid=0.
  - stall_cnt increments on each edge where out_valid=1 and out_ready=0.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - clr_cnt=1 zeroes both at the edge, with priority over increment.
  - flush does not affect the counters.
- Reset mid-operation: asserting rst_n low at any point forces the reset values immediately; any in-flight beats are lost.

Test Plan:
- Reset then stream A=0x11, B=0x22, C=0x33 with out_ready=1 -> each appears one cycle after acceptance, in_ready stays 1, stall_cnt=0.
- Send A, B with out_ready=0 -> after B, in_ready=0 (TWO) and outputs hold A. Raise out_ready -> A then B on consecutive cycles, stall_cnt=2 if held off for 2 output-valid cycles.
- In TWO, assert flush together with in_valid=1, ALU_result=0x44 -> next cycle out_valid=0, _WB=0, in_ready=1, and 0x44 never appears.
- Idle for 70000 cycles with CNT_W=16 -> bubble_cnt saturates at 0xFFFF. Pulse clr_cnt -> bubble_cnt=0 the next cycle.
- Drop rst_n asynchronously mid-cycle while in ONE with _WB=2'b11 -> out_valid and _WB go to 0 without a clock edge. After release, in_ready=1 and the first new beat passes normally.
- With DATA_W=64, ADDR_W=6, send read_data=0xDEADBEEF_CAFEF00D, RegDst_address=6'd63 -> both appear bit-exact on the outputs.
